// File: rtl/pi1_mbox.sv
// pi1_mbox: PI1-attached mailbox FIFO with status, threshold interrupt and control registers.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   pi1_op_i            00 NOOP, 01 WRITE, 10 READ, 11 READWRITE
//   pi1_addr_i          word address, [1:0] selects DATA/STATUS/THRESH/CTRL
//   pi1_data_i/o        write data / read data (held until next completion)
//   pi1_sel_i           byte-lane enables
//   pi1_rdy_o           high when a new request can be accepted
//   intrqst_o           high while THRESH!=0 and count>=THRESH
module pi1_mbox #(
  parameter int ARCHBITSZ = 32,
  parameter int DEPTH = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [1:0]                                   pi1_op_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]     pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]                         pi1_data_i,
  output logic [ARCHBITSZ-1:0]                         pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]                       pi1_sel_i,
  output logic                                         pi1_rdy_o,
  output logic                                         intrqst_o
);
  localparam int ADDRW = ARCHBITSZ - $clog2(ARCHBITSZ/8);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = ARCHBITSZ / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_n;
  logic [1:0] r_op, r_addr;
  logic [ARCHBITSZ-1:0] r_data, r_dout, w_dout_n, w_wdata, w_status, w_rdval;
  logic [SW-1:0] r_sel;
  logic [ARCHBITSZ-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp, w_wp_n, w_rp_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [7:0] r_thresh, w_thresh_n;
  logic r_ovf, r_udf, w_ovf_n, w_udf_n, r_irq, w_irq_n;
  logic w_accept, w_done, w_rd, w_wr, w_empty, w_full, w_data_acc;
  logic w_pop, w_push, w_ctrl, w_flush, w_clr, w_unused;
  assign w_unused = ^pi1_addr_i[ADDRW-1:2];
  for (genvar b = 0; b < SW; b++) begin : g_lane
    assign w_wdata[8*b +: 8] = r_sel[b] ? r_data[8*b +: 8] : 8'h00;
  end
  assign w_accept   = (r_state == IDLE) && (pi1_op_i != 2'b00);
  assign w_done     = (r_state == BUSY);
  assign w_rd       = r_op[1];
  assign w_wr       = r_op[0];
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_data_acc = w_done && (r_addr == 2'd0);
  // READWRITE pops before pushing, so a full FIFO still accepts the new word
  assign w_pop      = w_data_acc && w_rd && !w_empty;
  assign w_push     = w_data_acc && w_wr && (!w_full || w_pop);
  assign w_ctrl     = w_done && (r_addr == 2'd3) && w_wr && r_sel[0];
  assign w_flush    = w_ctrl && r_data[0];
  assign w_clr      = w_ctrl && r_data[1];
  assign w_status   = {{(ARCHBITSZ-12){1'b0}}, r_udf, r_ovf, w_full, w_empty, 8'(r_cnt)};
  always_comb begin
    w_state_n  = (r_state == IDLE) ? (w_accept ? BUSY : IDLE) : IDLE;
    w_cnt_n    = w_flush ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
    w_wp_n     = w_flush ? '0 : r_wp + AW'(w_push);
    w_rp_n     = w_flush ? '0 : r_rp + AW'(w_pop);
    w_ovf_n    = !w_clr && (r_ovf || (w_data_acc && w_wr && !w_push));
    w_udf_n    = !w_clr && (r_udf || (w_data_acc && w_rd && w_empty));
    w_thresh_n = (w_done && r_addr == 2'd2 && w_wr && r_sel[0]) ? r_data[7:0] : r_thresh;
    w_rdval    = (r_addr == 2'd0) ? (w_empty ? '0 : r_mem[r_rp]) :
                 (r_addr == 2'd1) ? w_status :
                 (r_addr == 2'd2) ? {{(ARCHBITSZ-8){1'b0}}, r_thresh} : '0;
    w_dout_n   = !w_done ? r_dout : (w_rd ? w_rdval : '0);
    // interrupt tracks post-update count/threshold so it moves on the same edge as count
    w_irq_n    = (w_thresh_n != 8'd0) && (9'(w_cnt_n) >= 9'(w_thresh_n));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_op     <= 2'b00;
      r_addr   <= 2'b00;
      r_data   <= '0;
      r_sel    <= '0;
      r_dout   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_thresh <= 8'd0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      if (w_accept) begin
        r_op   <= pi1_op_i;
        r_addr <= pi1_addr_i[1:0];
        r_data <= pi1_data_i;
        r_sel  <= pi1_sel_i;
      end
      r_dout   <= w_dout_n;
      r_wp     <= w_wp_n;
      r_rp     <= w_rp_n;
      r_cnt    <= w_cnt_n;
      r_thresh <= w_thresh_n;
      r_ovf    <= w_ovf_n;
      r_udf    <= w_udf_n;
      r_irq    <= w_irq_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= w_wdata;
  end
  assign pi1_rdy_o  = (r_state == IDLE);
  assign pi1_data_o = r_dout;
  assign intrqst_o  = r_irq;
endmodule

// File: doc/pi1_mbox.md
PI1_MBOX -- requirements
Module: pi1_mbox

Interface
REQ-001 SHALL have parameter ARCHBITSZ, default 32, meaning the data word width in bits (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 8, meaning the FIFO entry count (power of 2, 2..128).
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, reset, asynchronous and active-high.
REQ-005 SHALL have port pi1_op_i, input, 2 bits: 00 NOOP, 01 WRITE, 10 READ, 11 READWRITE.
REQ-006 SHALL have port pi1_addr_i, input, ARCHBITSZ-clog2(ARCHBITSZ/8) bits, word address; only bits [1:0] are decoded.
REQ-007 SHALL have port pi1_data_i, input, ARCHBITSZ bits, write data.
REQ-008 SHALL have port pi1_data_o, output, ARCHBITSZ bits, read data.
REQ-009 SHALL have port pi1_sel_i, input, ARCHBITSZ/8 bits, byte-lane enables.
REQ-010 SHALL have port pi1_rdy_o, output, 1 bit, high when a new request can be accepted.
REQ-011 SHALL have port intrqst_o, output, 1 bit, interrupt request to the pu intrqst_i.

Function
REQ-012 SHALL accept a request on a rising edge where pi1_rdy_o=1 and pi1_op_i!=NOOP, capturing op, addr[1:0], data and sel.
REQ-013 SHALL use FSM IDLE->BUSY on accept, and BUSY->IDLE unconditionally on the next edge, executing the captured op on that edge.
REQ-014 SHALL drive pi1_rdy_o=1 in IDLE and 0 in BUSY, giving a fixed 1 wait cycle per access.
REQ-015 SHALL present the read result on pi1_data_o from the BUSY->IDLE edge and hold it until the next completion; WRITE completions drive 0.
REQ-016 Register map: addr 0 = DATA, 1 = STATUS, 2 = THRESH, 3 = CTRL.
REQ-017 DATA: WRITE pushes; lanes with sel=0 are pushed as 0; READ pops the head and returns it.
REQ-018 DATA READWRITE SHALL atomically return the head, pop it, and push the write data; it SHALL succeed when full; when empty it returns 0, sets UNDERFLOW and still pushes.
REQ-019 A push while full SHALL be dropped with STATUS.OVERFLOW set sticky; a pop while empty SHALL return 0 with UNDERFLOW set sticky, and count unchanged.
REQ-020 STATUS read: [7:0] count (0..DEPTH), [8] empty, [9] full, [10] OVERFLOW, [11] UNDERFLOW, other bits 0; writes ignored.
REQ-021 THRESH: 8-bit register at bits [7:0]; WRITE honours sel[0]; READ returns it zero-extended; READWRITE returns the old value and writes the new one.
REQ-022 CTRL write: bit0=1 flushes the FIFO (count 0, pointers 0); bit1=1 clears OVERFLOW/UNDERFLOW; it honours sel[0]; reads return 0.
REQ-023 Read/write pointers SHALL be clog2(DEPTH) bits wrapping modulo DEPTH; count is clog2(DEPTH)+1 bits.
REQ-024 intrqst_o SHALL be registered and equal (THRESH!=0 && count>=THRESH) evaluated on post-update state, so it changes on the same edge as count.
REQ-025 Inputs while BUSY SHALL be ignored; the initiator holds op until it samples rdy high.

Reset
REQ-026 On rst_i high, state SHALL go immediately to IDLE: pi1_rdy_o=1, pi1_data_o=0, intrqst_o=0, count=0, pointers=0, THRESH=0, flags=0.
REQ-027 Reset asserted during BUSY SHALL abort the pending op with no FIFO or register change; FIFO storage contents need not be cleared.

Verification
REQ-028 Push 0x11,0x22,0x33 to DATA, then READ DATA x3 -> returns 0x11,0x22,0x33; each access has rdy low exactly 1 cycle; STATUS then reads 0x100.
REQ-029 Push DEPTH+1 words -> STATUS = count DEPTH, full=1, OVERFLOW=1; the extra word is absent from the pops; CTRL write 0x2 clears OVERFLOW only.
REQ-030 READ DATA when empty -> data 0, STATUS bit11=1, count 0; a READWRITE of 0xAB when full -> returns the old head, count stays DEPTH, and 0xAB pops last.
REQ-031 THRESH=2: the first push keeps intrqst_o=0; intrqst_o=1 on the edge completing the second push; a pop drops it the same edge.
REQ-032 Push with sel=0b0101 of 0xAABBCCDD -> popped as 0x00BB00DD.
REQ-033 Assert rst_i mid-BUSY of a DATA write -> rdy_o=1 asynchronously, count 0, and no push is observed after release.
